// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants for the BCD MM:SS countdown timer: FSM encoding and digit-field layout.
package bcd_countdown_timer_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    // Digit positions inside the 16-bit word {min_tens, min_units, sec_tens, sec_units}
    localparam int unsigned SEC_UNITS_IDX = 0;
    localparam int unsigned SEC_TENS_IDX  = 1;
    localparam int unsigned MIN_UNITS_IDX = 2;
    localparam int unsigned MIN_TENS_IDX  = 3;

    localparam int unsigned SEC_UNITS_LSB = SEC_UNITS_IDX * DIGIT_W;
    localparam int unsigned SEC_TENS_LSB  = SEC_TENS_IDX * DIGIT_W;
    localparam int unsigned MIN_UNITS_LSB = MIN_UNITS_IDX * DIGIT_W;
    localparam int unsigned MIN_TENS_LSB  = MIN_TENS_IDX * DIGIT_W;

    localparam logic [BCD_W-1:0] BCD_ZERO = 16'h0000;
    localparam logic [BCD_W-1:0] BCD_ONE  = 16'h0001;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: clear, clamped load, and decrement with wrap to MAX and borrow out.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic               ck,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow_c
);

    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] load_clamped;

    // Out-of-range presets saturate to the digit maximum rather than wrapping
    assign load_clamped = (load_val > MAX_D) ? MAX_D : load_val;
    assign borrow_c     = en && (q == '0);

    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_clamped;
        end else if (en) begin
            q <= borrow_c ? MAX_D : q - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD MM:SS countdown timer: FSM, command priority decode and end-of-count pulse.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned SEC_TENS_MAX = 5,
    parameter int unsigned UNITS_MAX    = 9
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             tick,
    output logic [BCD_W-1:0] q,
    output logic             running,
    output logic             zero,
    output logic             done
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic               running_nx;
    logic               done_nx;

    logic               load_en;
    logic               dec_en;
    logic               last_tick;
    logic [NUM_DIGITS:0] borrow;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit;
    logic               unused_borrow;

    // Load is refused while running; a refused load does not mask lower-priority commands
    assign load_en   = !clr && load && (state != ST_RUN);
    assign dec_en    = !clr && !pause && tick && (state == ST_RUN);
    assign last_tick = dec_en && (q == BCD_ONE);

    assign borrow[0]     = dec_en;
    assign unused_borrow = borrow[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam int unsigned DMAX = (i == SEC_TENS_IDX) ? SEC_TENS_MAX : UNITS_MAX;

        bcd_digit_down #(
            .MAX(DMAX)
        ) u_digit (
            .ck       (ck),
            .rst_n    (rst_n),
            .clr      (clr),
            .load     (load_en),
            .load_val (load_val[i*DIGIT_W +: DIGIT_W]),
            .en       (borrow[i]),
            .q        (digit[i]),
            .borrow_c (borrow[i+1])
        );
    end

    assign q    = digit;
    assign zero = (q == BCD_ZERO);

    // Next-state decode: clr > load > pause > start > tick
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        if (clr) begin
            state_nx = ST_IDLE;
        end else if (load_en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (start && !zero) begin
                        state_nx = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nx = ST_PAUSE;
                    end else if (last_tick) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_DONE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
        running_nx = (state_nx == ST_RUN);
    end

    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= running_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a seconds-based model predicts each falling-edge result.
module tb_bcd_countdown_timer;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_RUN   = 2'd1;
    localparam logic [1:0] M_PAUSE = 2'd2;
    localparam logic [1:0] M_DONE  = 2'd3;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] q;
    logic        running;
    logic        zero;
    logic        done;

    typedef struct {
        string       tag;
        logic [15:0] q;
        logic        running;
        logic        done;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    int         m_sec;
    logic [1:0] m_st;
    logic       m_done;

    always #5 ck = ~ck;

    bcd_countdown_timer dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick     (tick),
        .q        (q),
        .running  (running),
        .zero     (zero),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int clamp_secs(input logic [15:0] v);
        int d[4];
        for (int i = 0; i < 4; i++) d[i] = int'(v[i*4 +: 4]);
        if (d[0] > 9) d[0] = 9;
        if (d[1] > 5) d[1] = 5;
        if (d[2] > 9) d[2] = 9;
        if (d[3] > 9) d[3] = 9;
        return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    // Outputs settle on the falling edge; compare the pending expectation on the following rising edge
    always @(posedge ck) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, ".q"},       32'(q),       32'(mon_e.q));
            check({mon_e.tag, ".running"}, 32'(running), 32'(mon_e.running));
            check({mon_e.tag, ".done"},    32'(done),    32'(mon_e.done));
            check({mon_e.tag, ".zero"},    32'(zero),    32'(mon_e.zero));
        end
    end

    task automatic drive(input string tag, input logic c, input logic l, input logic [15:0] lv,
                         input logic s, input logic p, input logic t);
        @(posedge ck);
        #1;
        clr = c; load = l; load_val = lv; start = s; pause = p; tick = t;
        m_done = 1'b0;
        if (c) begin
            m_sec = 0;
            m_st  = M_IDLE;
        end else if (l && m_st != M_RUN) begin
            m_sec = clamp_secs(lv);
            m_st  = M_IDLE;
        end else if (p && m_st == M_RUN) begin
            m_st = M_PAUSE;
        end else if (s && (m_st == M_IDLE || m_st == M_PAUSE) && m_sec != 0) begin
            m_st = M_RUN;
        end else if (t && m_st == M_RUN) begin
            m_sec--;
            if (m_sec == 0) begin
                m_st   = M_DONE;
                m_done = 1'b1;
            end
        end
        sb.push_back('{tag, to_bcd(m_sec), m_st == M_RUN, m_done, m_sec == 0});
    endtask

    task automatic do_idle(input string tag);  drive(tag, 0, 0, 16'h0, 0, 0, 0); endtask
    task automatic do_load(input string tag, input logic [15:0] v); drive(tag, 0, 1, v, 0, 0, 0); endtask
    task automatic do_start(input string tag); drive(tag, 0, 0, 16'h0, 1, 0, 0); endtask
    task automatic do_pause(input string tag); drive(tag, 0, 0, 16'h0, 0, 1, 0); endtask
    task automatic do_clr(input string tag);   drive(tag, 1, 0, 16'h0, 0, 0, 0); endtask

    task automatic do_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) drive(tag, 0, 0, 16'h0, 0, 0, 1);
    endtask

    // Reset asserted and released between edges; outputs must clear without waiting for a clock
    task automatic async_reset(input string tag);
        @(posedge ck);
        #1;
        clr = 0; load = 0; load_val = 16'h0; start = 0; pause = 0; tick = 0;
        rst_n = 1'b0;
        #1;
        check({tag, ".q"},       32'(q),       32'h0);
        check({tag, ".running"}, 32'(running), 32'h0);
        check({tag, ".done"},    32'(done),    32'h0);
        check({tag, ".zero"},    32'(zero),    32'h1);
        #1;
        rst_n  = 1'b1;
        m_sec  = 0;
        m_st   = M_IDLE;
        m_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_sec  = 0;
        m_st   = M_IDLE;
        m_done = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        check("reset.q",       32'(q),       32'h0);
        check("reset.running", 32'(running), 32'h0);
        check("reset.done",    32'(done),    32'h0);
        check("reset.zero",    32'(zero),    32'h1);
        rst_n = 1'b1;

        // Simple run to zero, then DONE ignores start/tick and accepts load
        do_load("simple.load", 16'h0003);
        do_start("simple.start");
        do_ticks("simple.tick", 3);
        do_idle("simple.after");
        do_start("done.start");
        do_ticks("done.tick", 2);
        do_load("done.load", 16'h0002);

        // Borrow chain across all digits, load accepted in PAUSE
        do_load("borrow.load", 16'h1000);
        do_start("borrow.start");
        do_ticks("borrow.tick", 1);
        do_pause("borrow.pause");
        do_load("borrow.load2", 16'h0100);
        do_start("borrow.start2");
        do_ticks("borrow.tick2", 1);
        do_clr("borrow.clr");

        // Pause priority and load refused in RUN
        do_load("pause.load", 16'h0010);
        do_start("pause.start");
        do_ticks("pause.tick", 2);
        drive("pause.pause_start", 0, 0, 16'h0, 1, 1, 0);
        do_ticks("pause.held", 3);
        do_start("pause.resume");
        do_ticks("pause.tick2", 1);
        do_load("pause.load_run", 16'h1234);
        do_ticks("pause.tick3", 1);

        // Clamping and start refused at zero
        do_clr("clamp.clr0");
        do_load("clamp.ffff", 16'hFFFF);
        do_load("clamp.3a7f", 16'h3A7F);
        do_start("clamp.start");
        do_ticks("clamp.tick", 1);
        do_clr("clamp.clr");
        do_start("zstart.start");
        do_ticks("zstart.tick", 1);

        // Asynchronous reset mid-run
        do_load("arst.load", 16'h0530);
        do_start("arst.start");
        do_ticks("arst.tick", 4);
        async_reset("arst.reset");
        do_ticks("arst.post_tick", 2);
        do_load("arst.reload", 16'h0530);
        do_start("arst.restart");
        do_ticks("arst.tick2", 1);

        // clr wins over the final tick: no done pulse
        do_clr("clrlast.clr0");
        do_load("clrlast.load", 16'h0002);
        do_start("clrlast.start");
        do_ticks("clrlast.tick", 1);
        drive("clrlast.clr_tick", 1, 0, 16'h0, 0, 0, 1);
        do_idle("clrlast.after");

        repeat (2) @(posedge ck);
        #1;
        check("drain.pending", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Four-digit BCD MM:SS countdown timer. It is the down-counting counterpart of the team's BCD up-counter family: it is loaded with a preset and decrements by one second per tick.
- It generates the end-of-count event, which plays the role that cnt_max plays on the up-counters.
- It sits between the 1 Hz tick generator and the 7-segment display/alarm logic.

Parameters:
- SEC_TENS_MAX, 5, maximum value of the seconds-tens digit.
- UNITS_MAX, 9, maximum value of the seconds-units, minutes-units and minutes-tens digits.

Ports:
- ck  input  1  system clock; all state changes on the falling edge, as in the counter family.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear.
- load  input  1  load preset from load_val.
- load_val  input  16  BCD preset {min_tens, min_units, sec_tens, sec_units}.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- tick  input  1  one-cycle 1 Hz enable.
- q  output  16  current BCD count, same digit order as load_val.
- running  output  1  high while in RUN.
- zero  output  1  combinational: q == 16'h0000.
- done  output  1  registered one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (rst_n low, asynchronous): q=0, state IDLE, running=0, done=0. Counting resumes on the first falling edge after rst_n rises.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN).
- Per-edge priority: clr > load > pause > start > tick.
- clr, in any state: q=0, goes to IDLE, done=0.
- load:
  - Accepted in IDLE, PAUSE and DONE. q=load_val, next state IDLE.
  - Ignored in RUN.
  - Digit clamping on load: sec_tens > SEC_TENS_MAX loads SEC_TENS_MAX. Any other digit > 9 (A–F) loads 9.
  - Example: 16'h3A7F loads 16'h3959.
- start:
  - IDLE or PAUSE with q != 0: goes to RUN.
  - q == 0: ignored, state unchanged.
  - In RUN or DONE: no effect.
- pause: RUN goes to PAUSE, q held. In other states it has no effect. When pause and start are asserted on the same edge, pause wins.
- tick:
  - Acts only in RUN; ignored in every other state.
  - Each tick decrements q by one second using BCD borrow:
    - sec_units 0 → 9, borrow to sec_tens;
    - sec_tens 0 → SEC_TENS_MAX, borrow to min_units;
    - min_units 0 → 9, borrow to min_tens.
  - Example: 10:00 → 09:59.
  - No wrap below 00:00. A tick at q=00:01 sets q=00:00, moves to DONE and asserts done on that same edge.
- done: high for exactly one cycle, on the edge where q becomes zero in RUN. It is never asserted by clr, load or reset.
- DONE: q stays 00:00 until load or clr, both of which return to IDLE.
- Latency: q updates on the falling edge where tick is sampled high. running falls on that same edge when q reaches zero.
- Ticks wider than one cycle: each high cycle counts as one tick. Edge detection is upstream's responsibility.

Decomposition:
- Shared package:
  - state encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
  - digit-field constants (bit slices of the 16-bit BCD word).
- Sub-module bcd_digit_down (parameter MAX): 4-bit digit with load, enable/borrow-in, borrow-out (asserted when digit==0 and enabled), wrap to MAX.
  - Instantiated four times with a ripple borrow chain.
  - Load clamping lives in the sub-module.
- Top level holds the FSM, the priority decode and the done register.

Test Plan:
- Reset and simple run: reset, load 16'h0003, start, 3 ticks. Required: q = 0002, 0001, 0000; done high for exactly one cycle on the third tick; running 1 → 0; state DONE.
- Borrow chain: load 16'h1000, start, 1 tick → q=16'h0959. Load 16'h0100 in PAUSE, start, 1 tick → q=16'h0059.
- Pause and priority:
  - Load 0010, start, 2 ticks → 0008.
  - pause+start on the same edge → PAUSE.
  - 3 ticks → q stays 0008.
  - start, 1 tick → 0007.
  - load during RUN → ignored.
- Clamping and zero-start:
  - load 16'hFFFF → q=16'h9959.
  - clr → q=0, zero=1.
  - start → running stays 0, done stays 0.
- Asynchronous reset mid-run: load 0530, start, 4 ticks, then pulse rst_n low between edges. Required: q=0 and running=0 immediately, no done pulse, ticks after release ignored until load+start.
- clr on the final tick: at q=0001 in RUN, assert clr and tick together → q=0, IDLE, done stays 0.
